// File: rtl/program_loader_host.sv
// ============================================================================
// Module      : program_loader_host
// Description : Host side of the CPU boot handshake. Waits for 0x99, sends the
//               program byte count, streams ROM words LSB first, awaits 0xAA.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader_host #(
    parameter int ROM_ADDRESS_BITWIDTH = 12,
    parameter int WORD_COUNT_BITWIDTH  = 13
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [WORD_COUNT_BITWIDTH-1:0]  program_word_count,
    input  logic                            rx_valid,
    input  logic [7:0]                      rx_data,
    input  logic                            tx_ready,
    output logic                            tx_valid,
    output logic [7:0]                      tx_data,
    output logic                            rom_read_enable,
    output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address,
    input  logic [31:0]                     rom_data,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_wait_99   = 3'd1;
    localparam logic [2:0] c_st_send_size = 3'd2;
    localparam logic [2:0] c_st_fetch     = 3'd3;
    localparam logic [2:0] c_st_latch     = 3'd4;
    localparam logic [2:0] c_st_send_word = 3'd5;
    localparam logic [2:0] c_st_wait_aa   = 3'd6;

    localparam logic [7:0] c_sync_byte = 8'h99;
    localparam logic [7:0] c_ack_byte  = 8'hAA;
    localparam int         c_size_pad  = 32 - WORD_COUNT_BITWIDTH - 2;

    logic [2:0]                     r_state;
    logic [WORD_COUNT_BITWIDTH-1:0] r_word_count;
    logic [WORD_COUNT_BITWIDTH-1:0] r_words_sent;
    logic [1:0]                     r_byte_idx;
    logic [23:0]                    r_shift;

    logic                           w_tx_fire;
    logic                           w_restart;
    logic [31:0]                    w_size;
    logic [WORD_COUNT_BITWIDTH-1:0] w_words_sent_next;

    assign w_tx_fire         = tx_valid && tx_ready;
    assign w_restart         = rx_valid && (rx_data == c_sync_byte);
    assign w_size            = {{c_size_pad{1'b0}}, r_word_count, 2'b00};
    assign w_words_sent_next = r_words_sent + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= c_st_idle;
            r_word_count    <= '0;
            r_words_sent    <= '0;
            r_byte_idx      <= '0;
            r_shift         <= '0;
            tx_valid        <= 1'b0;
            tx_data         <= 8'h00;
            rom_read_enable <= 1'b0;
            rom_address     <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            done            <= 1'b0;
            rom_read_enable <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_word_count <= program_word_count;
                        r_words_sent <= '0;
                        rom_address  <= '0;
                        error        <= 1'b0;
                        busy         <= 1'b1;
                        r_state      <= c_st_wait_99;
                    end
                end
                c_st_wait_99: begin
                    if (w_restart) begin
                        r_byte_idx <= 2'd0;
                        tx_valid   <= 1'b1;
                        tx_data    <= w_size[7:0];
                        r_shift    <= w_size[31:8];
                        r_state    <= c_st_send_size;
                    end
                end
                c_st_send_size, c_st_send_word: begin
                    // A fresh 0x99 means the CPU rebooted mid-transfer.
                    if (w_restart) begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        tx_valid <= 1'b0;
                        r_state  <= c_st_idle;
                    end else if (w_tx_fire) begin
                        if (r_byte_idx == 2'd3) begin
                            tx_valid <= 1'b0;
                            if (r_state == c_st_send_size) begin
                                if (r_word_count == '0) begin
                                    r_state <= c_st_wait_aa;
                                end else begin
                                    rom_read_enable <= 1'b1;
                                    r_state         <= c_st_fetch;
                                end
                            end else begin
                                r_words_sent <= w_words_sent_next;
                                rom_address  <= rom_address + 1'b1;
                                if (w_words_sent_next == r_word_count) begin
                                    r_state <= c_st_wait_aa;
                                end else begin
                                    rom_read_enable <= 1'b1;
                                    r_state         <= c_st_fetch;
                                end
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            tx_data    <= r_shift[7:0];
                            r_shift    <= {8'h00, r_shift[23:8]};
                        end
                    end
                end
                c_st_fetch: begin
                    if (w_restart) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= c_st_idle;
                    end else begin
                        r_state <= c_st_latch;
                    end
                end
                c_st_latch: begin
                    if (w_restart) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= c_st_idle;
                    end else begin
                        r_byte_idx <= 2'd0;
                        tx_valid   <= 1'b1;
                        tx_data    <= rom_data[7:0];
                        r_shift    <= rom_data[31:8];
                        r_state    <= c_st_send_word;
                    end
                end
                c_st_wait_aa: begin
                    if (rx_valid) begin
                        if (rx_data == c_ack_byte) begin
                            done <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                        busy    <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/program_loader_host.md
Name: program_loader_host

Overview:
- Host-side peer of the CPU's boot handshake. It is the sender that answers the CPU's UART controller.
- Waits for the CPU's 0x99 byte, sends the 4-byte program size, then streams program words read from a local program ROM, then waits for the CPU's 0xAA acknowledge.
- Sits between a UART byte receiver/transmitter pair and a program ROM. Used in the loopback test rig and the FPGA-to-FPGA boot path.

Parameters:
- ROM_ADDRESS_BITWIDTH, 12: width of the ROM word address. Maximum program length is 2^ROM_ADDRESS_BITWIDTH words.
- WORD_COUNT_BITWIDTH, 13: width of the program_word_count input. Must be at least ROM_ADDRESS_BITWIDTH+1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE
- program_word_count  input  WORD_COUNT_BITWIDTH  number of 32-bit words to send; latched on start
- rx_valid  input  1  a received byte is presented this cycle (single-cycle strobe)
- rx_data  input  8  received byte from the CPU
- tx_ready  input  1  transmitter can accept a byte
- tx_valid  output  1  byte offered to the transmitter
- tx_data  output  8  byte to transmit
- rom_read_enable  output  1  ROM read strobe
- rom_address  output  ROM_ADDRESS_BITWIDTH  ROM word address
- rom_data  input  32  ROM word, valid exactly 1 cycle after rom_read_enable
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on successful completion
- error  output  1  sticky protocol error; cleared by reset or by the next accepted start

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE
  - all outputs 0: tx_valid, tx_data=0x00, rom_read_enable, rom_address, busy, done, error
  - byte index and word counter to 0
- TX handshake:
  - A byte transfers on a cycle where tx_valid && tx_ready.
  - Once tx_valid is high, tx_valid and tx_data stay stable until that transfer.
  - After the transfer, the next byte may be presented on the following cycle.
- RX: rx_data is consumed only on cycles with rx_valid=1. There is no backpressure on RX.
- Size field:
  - Value = program_word_count*4 (a byte count), zero-extended to 32 bits.
  - Sent little-endian, LSB byte first.
- Program words: each 32-bit word sent little-endian, bits[7:0] first.
- States:
  - IDLE
    - On start: latch program_word_count, clear error, set rom_address=0, go to WAIT_99.
    - start in any other state is ignored.
  - WAIT_99
    - rx_valid && rx_data==0x99: go to SEND_SIZE, byte index=0.
    - Any other received byte is discarded; no error.
  - SEND_SIZE
    - Present size byte[index]; index increments on each transfer.
    - After byte 3 transfers:
      - word count 0: go to WAIT_AA.
      - otherwise: go to FETCH.
  - FETCH
    - Assert rom_read_enable for exactly 1 cycle at the current rom_address, then go to LATCH.
  - LATCH
    - Capture rom_data into the word shift register, go to SEND_WORD, byte index=0.
  - SEND_WORD
    - Present the word bytes in order.
    - After byte 3 transfers: increment the sent-word counter and rom_address.
      - Counter == latched count: go to WAIT_AA.
      - Otherwise: go to FETCH.
  - WAIT_AA
    - rx_valid && rx_data==0xAA: pulse done for 1 cycle, go to IDLE.
    - rx_valid with any other byte: set error, go to IDLE (no done).
  - RX bytes arriving during SEND_SIZE, FETCH, LATCH or SEND_WORD are discarded, with one exception: a byte of 0x99 sets error and aborts to IDLE (the CPU has restarted).
- Latency, from the byte-3 transfer of one word to tx_valid for the next word's byte 0: 3 cycles (FETCH, LATCH, then SEND_WORD presents).
- The rom_address counter wraps naturally. This is unreachable when program_word_count ≤ 2^ROM_ADDRESS_BITWIDTH.
- An abort to IDLE drops tx_valid on the next cycle. A byte already transferred is not recalled.
- busy=0 in IDLE only. done and error are mutually exclusive in any cycle.
- Reset mid-load returns to IDLE immediately. No partial state is retained.

Test Plan:
- Nominal load:
  - Stimulus: count=2; ROM[0]=0x11223344, ROM[1]=0xA5A5_0F0F; tx_ready=1; rx 0x99 then 0xAA.
  - Required: tx sequence 08 00 00 00 44 33 22 11 0F 0F A5 A5; done pulses once; error=0.
- Zero-length load:
  - Stimulus: count=0; rx 0x99.
  - Required: tx 00 00 00 00, then WAIT_AA; after rx 0xAA, done=1 with no ROM read.
- Backpressure:
  - Stimulus: count=1; tx_ready toggles 1-of-3 cycles.
  - Required: tx_data is held stable for every cycle tx_valid=1 without a transfer; byte order is unchanged.
- Noise before sync and bad ack:
  - Stimulus: rx 0x55, 0x00, then 0x99; after the words, rx 0x42.
  - Required: the first two bytes are ignored; error=1, no done, busy=0. The next start clears error.
- Restart and reset abort:
  - Stimulus: rx 0x99 during SEND_WORD.
  - Required: error=1, IDLE.
  - Stimulus: separately, assert reset during SEND_SIZE.
  - Required: all outputs are 0 on the same cycle.
- Start while busy:
  - Stimulus: pulse start in WAIT_AA.
  - Required: ignored; count not relatched; load completes normally.
